fetch_stage: RTL and testbench

//  Front-end fetch stage between the PC and the decode stage. Holds the fetch PC, presents it
//  to instruction_cache, and captures each returned 32-bit instruction with its PC into a small

---
 rtl/fetch_stage.sv | 110 +++++++++++
 tb/tb_fetch_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Front-end fetch stage: holds the fetch PC, captures cache hits into a small in-order
// queue, drains that queue to decode over valid/ready, and flushes on execute redirects.
module fetch_stage #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        reset,
    output logic [63:0] icache_pc,
    input  logic        icache_r,
    input  logic [31:0] icache_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        de_valid,
    input  logic        de_ready,
    output logic [31:0] de_instr,
    output logic [63:0] de_pc,
    output logic [63:0] de_npc
);

    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;

    logic [31:0]   instr_mem_q [QUEUE_DEPTH];
    logic [63:0]   pc_mem_q    [QUEUE_DEPTH];

    logic          full;
    logic          empty;
    logic          enq;
    logic          deq;
    logic [63:0]   redirect_tgt;
    logic [31:0]   head_instr;
    logic [63:0]   head_pc;

    assign full         = (count_q == (PW+1)'(QUEUE_DEPTH));
    assign empty        = (count_q == '0);
    // A redirect squashes the returning word and blocks any handshake this cycle.
    assign enq          = icache_r & ~full & ~redirect_valid;
    assign de_valid     = ~empty & ~redirect_valid;
    assign deq          = de_valid & de_ready;
    assign redirect_tgt = redirect_pc & ~64'd3;

    assign icache_pc    = fetch_pc_q;

    // Head is read from the registered storage only, never from the cache bus.
    assign head_instr   = instr_mem_q[rd_ptr_q];
    assign head_pc      = pc_mem_q[rd_ptr_q];
    assign de_instr     = empty ? 32'd0 : head_instr;
    assign de_pc        = empty ? 64'd0 : head_pc;
    assign de_npc       = empty ? 64'd0 : head_pc + 64'd4;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_tgt;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (enq) begin
                fetch_pc_d = fetch_pc_q + 64'd4;
                wr_ptr_d   = wr_ptr_q + PW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (enq && !deq) begin
                count_d = count_q + (PW+1)'(1);
            end else if (!enq && deq) begin
                count_d = count_q - (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage entries carry no reset; validity is tracked purely by count/pointers.
    generate
        for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_entry
            logic entry_we;
            assign entry_we = enq && (wr_ptr_q == PW'(gi));
            always_ff @(posedge CLK) begin
                if (entry_we) begin
                    instr_mem_q[gi] <= icache_instr;
                    pc_mem_q[gi]    <= fetch_pc_q;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a cache model feeds words derived from the PC and a
// queue of expected {pc, instr} entries is checked against each decode handshake.
module tb_fetch_stage;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] ifn(input logic [63:0] pc);
        return pc[31:0] ^ pc[63:32] ^ 32'h5A5A_C3C3;
    endfunction

    // Main DUT (RESET_PC = 0)
    logic        reset;
    logic [63:0] icache_pc;
    logic        icache_r;
    logic [31:0] icache_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        de_valid;
    logic        de_ready;
    logic [31:0] de_instr;
    logic [63:0] de_pc;
    logic [63:0] de_npc;

    assign icache_instr = ifn(icache_pc);

    fetch_stage #(.RESET_PC(64'h0), .QUEUE_DEPTH(DEPTH)) dut (
        .CLK           (CLK),
        .reset         (reset),
        .icache_pc     (icache_pc),
        .icache_r      (icache_r),
        .icache_instr  (icache_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .de_valid      (de_valid),
        .de_ready      (de_ready),
        .de_instr      (de_instr),
        .de_pc         (de_pc),
        .de_npc        (de_npc)
    );

    // Wrap-around DUT (RESET_PC at the top of the address space)
    logic        reset_w;
    logic [63:0] icache_pc_w;
    logic        icache_r_w;
    logic [31:0] icache_instr_w;
    logic        redirect_valid_w;
    logic [63:0] redirect_pc_w;
    logic        de_valid_w;
    logic        de_ready_w;
    logic [31:0] de_instr_w;
    logic [63:0] de_pc_w;
    logic [63:0] de_npc_w;

    assign icache_instr_w = ifn(icache_pc_w);

    fetch_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .QUEUE_DEPTH(DEPTH)) dut_w (
        .CLK           (CLK),
        .reset         (reset_w),
        .icache_pc     (icache_pc_w),
        .icache_r      (icache_r_w),
        .icache_instr  (icache_instr_w),
        .redirect_valid(redirect_valid_w),
        .redirect_pc   (redirect_pc_w),
        .de_valid      (de_valid_w),
        .de_ready      (de_ready_w),
        .de_instr      (de_instr_w),
        .de_pc         (de_pc_w),
        .de_npc        (de_npc_w)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        sb[$];
    logic [63:0] m_pc;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive at posedge+1, check at posedge+4, update model after edge.
    task automatic cycle(input logic hit, input logic rdy, input logic rv, input logic [63:0] rpc);
        logic exp_valid;
        logic enq;
        logic deq;
        ent_t head;
        icache_r       = hit;
        de_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #3;
        exp_valid = (sb.size() != 0) && !rv;
        chk("icache_pc", icache_pc, m_pc);
        chk("de_valid", {63'd0, de_valid}, {63'd0, exp_valid});
        if (sb.size() != 0) begin
            head = sb[0];
            chk("de_pc", de_pc, head.pc);
            chk("de_instr", {32'd0, de_instr}, {32'd0, head.instr});
            chk("de_npc", de_npc, head.pc + 64'd4);
        end else begin
            chk("de_pc_empty", de_pc, 64'd0);
            chk("de_instr_empty", {32'd0, de_instr}, 64'd0);
        end
        enq = hit && (sb.size() < DEPTH) && !rv;
        deq = exp_valid && rdy;
        if (deq)
            $display("deq pc=%h instr=%h npc=%h", de_pc, de_instr, de_npc);
        if (rv)
            $display("redirect to %h", rpc);
        @(posedge CLK);
        #1;
        if (rv) begin
            sb.delete();
            m_pc = rpc & ~64'd3;
        end else begin
            if (deq) void'(sb.pop_front());
            if (enq) begin
                sb.push_back('{pc: m_pc, instr: ifn(m_pc)});
                m_pc = m_pc + 64'd4;
            end
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
        sb.delete();
        m_pc = 64'h0;
        #3;
        chk("rst_de_valid", {63'd0, de_valid}, 64'd0);
        chk("rst_icache_pc", icache_pc, 64'h0);
        chk("rst_de_pc", de_pc, 64'd0);
        chk("rst_de_npc", de_npc, 64'd0);
        @(posedge CLK);
        #1;
        reset = 1'b0;
        $display("reset released");
    endtask

    initial begin
        reset            = 1'b1;
        icache_r         = 1'b1;
        de_ready         = 1'b1;
        redirect_valid   = 1'b0;
        redirect_pc      = 64'h0;
        reset_w          = 1'b1;
        icache_r_w       = 1'b1;
        de_ready_w       = 1'b1;
        redirect_valid_w = 1'b0;
        redirect_pc_w    = 64'h0;

        // Steady stream from reset
        do_reset(2);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 64'h0);

        // Decode stalled: queue fills to 4 and fetch PC parks at 0x10
        do_reset(1);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 64'h0);
        #3;
        chk("full_hold_pc", icache_pc, 64'h10);
        chk("full_head_pc", de_pc, 64'h0);
        @(posedge CLK);
        #1;
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b0, 64'h0);

        // Cache misses mid-stream
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 64'h0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 64'h0);

        // Redirect with three entries queued, unaligned target
        do_reset(1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 64'h0);
        cycle(1'b1, 1'b1, 1'b1, 64'h103);
        #3;
        chk("redir_icache_pc", icache_pc, 64'h100);
        chk("redir_de_valid", {63'd0, de_valid}, 64'd0);
        @(posedge CLK);
        #1;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 64'h0);

        // Redirect while decode is ready and queue non-empty
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0, 64'h0);
        cycle(1'b1, 1'b1, 1'b1, 64'h200);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 64'h0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 19) == 0), {$urandom, $urandom});
        end

        // PC wrap at the top of the address space, then reset mid-stream
        reset_w = 1'b0;
        #3;
        chk("wrap_icache_pc0", icache_pc_w, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_de_valid0", {63'd0, de_valid_w}, 64'd0);
        @(posedge CLK);
        #4;
        chk("wrap_de_valid1", {63'd0, de_valid_w}, 64'd1);
        chk("wrap_de_pc1", de_pc_w, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_de_npc1", de_npc_w, 64'h0);
        chk("wrap_icache_pc1", icache_pc_w, 64'h0);
        $display("wrap deq pc=%h npc=%h", de_pc_w, de_npc_w);
        @(posedge CLK);
        #4;
        chk("wrap_de_pc2", de_pc_w, 64'h0);
        chk("wrap_de_npc2", de_npc_w, 64'h4);
        $display("wrap deq pc=%h npc=%h", de_pc_w, de_npc_w);
        reset_w = 1'b1;
        @(posedge CLK);
        #4;
        chk("wrap_rst_de_valid", {63'd0, de_valid_w}, 64'd0);
        chk("wrap_rst_icache_pc", icache_pc_w, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_rst_de_pc", de_pc_w, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
